decode_exec_skid: RTL and testbench
===================================

// Module: decode_exec_skid
// PURPOSE
//  Two-entry skid buffer forming the decode->execute pipeline register. Captures decoded
//  bundle (pc, raw instruction, op, sign-extended immediate, operands, rd/wen) from decode.
//  Presents it to execute with a valid/ready handshake.
//  Cuts the combinational ready path from execute back into decode. Supports a single-cycle
//  flush for branch/jump redirects.
// PARAMETERS
//  XLEN     64   datapath width (pc, imm, operand data)
//  OP_W     6    width of the decoded op field (decode_data_t encoding, carried opaquely)
// PORTS
//  clk           in   1      single clock, all state on rising edge
//  reset         in   1      asynchronous, active-low reset
//  flush         in   1      redirect from execute: kill all buffered and incoming entries
//  in_valid      in   1      decode presents a bundle
//  in_ready      out  1      buffer can accept (registered, no comb path from out_ready)
//  in_pc         in   XLEN   instruction pc
//  in_instr      in   32     raw instruction word
//  in_op         in   OP_W   decoded op
//  in_sextimm    in   XLEN   sign-extended immediate
//  in_rs1_data   in   XLEN   operand 1
//  in_rs2_data   in   XLEN   operand 2
//  in_rd         in   5      destination register index
//  in_wen        in   1      register write enable
//  out_valid     out  1      head entry valid toward execute
//  out_ready     in   1      execute accepts head entry
//  out_pc/out_instr/out_op/out_sextimm/out_rs1_data/out_rs2_data/out_rd/out_wen
//                out  (as in_*)  head-entry payload, driven straight from storage registers
//  occupancy     out  2      entries held (0..2), debug/perf
// BEHAVIOUR
//  - Storage: 2 entries, head/tail pointers (1 bit each, wrap 1->0), count 0..2.
//  - push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
//  - in_ready = (count != 2), from registered count only. out_valid = (count != 0).
//  - Latency: bundle pushed in cycle N is visible on out_* in cycle N+1 (if buffer was empty).
//  - Ordering strictly FIFO; payload never modified; in_op/in_sextimm carried bit-exact.
//  - Count transitions: push only +1; pop only -1; push&pop unchanged (count 1 only, since
//    count 0 has no pop and count 2 has no push); neither unchanged.
//  - Simultaneous push & pop at count 1:
//    - head advances; the new bundle is written at tail.
//    - Next cycle: out_* = new bundle, count stays 1.
//  - Payload registers written only on push; head entry must not change while out_valid &
//    ~out_ready (stable-under-stall rule).
//  - flush (highest priority):
//    - next edge count<=0 and head<=0, tail<=0.
//    - Any push/pop handshake in the flush cycle is discarded; execute must ignore out_* that
//      cycle.
//    - in_ready/out_valid follow count, so from cycle after flush: in_ready=1, out_valid=0.
//  - Reset (async assert, any time incl. mid-transfer): count=0, head=tail=0, out_valid=0,
//    in_ready=1 after deassert, occupancy=0, all payload storage and out_* = 0.
//    Reset deassertion takes effect at the next clk edge.
//  - No X propagation: out_* reflect storage even when out_valid=0 (value don't-care to consumer).
// TESTING
//  1. Reset mid-stream with count=2 -> out_valid=0, occupancy=0, out_pc=0 immediately;
//     in_ready=1 next cycle.
//  2. Push pc=0x8000_0000, op=ADDI, imm=0xFFFF_FFFF_FFFF_FFFC with out_ready=1 ->
//     appears next cycle bit-exact, then out_valid=0.
//  3. out_ready=0, push A,B -> in_ready=0 after 2nd push. A held stable 5 cycles.
//     Release -> A then B on consecutive cycles.
//  4. count=1, push C and pop head same cycle -> next cycle out=C, occupancy=1.
//  5. count=2 plus in_valid=1 with flush=1 -> next cycle out_valid=0, occupancy=0,
//     incoming bundle dropped.
//  6. Random valid/ready toggling, 10k bundles vs. scoreboard -> no loss/duplication/reorder.

Source files
------------

// File: rtl/decode_exec_skid.sv
// Two-entry skid buffer acting as the decode->execute pipeline register.
// in_ready depends only on the registered count, so out_ready has no combinational path back into decode.
module decode_exec_skid #(
  parameter int XLEN = 64,
  parameter int OP_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic [OP_W-1:0] in_op,
  input  logic [XLEN-1:0] in_sextimm,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [4:0]      in_rd,
  input  logic            in_wen,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [OP_W-1:0] out_op,
  output logic [XLEN-1:0] out_sextimm,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic [1:0]      occupancy
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] sextimm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd;
    logic            wen;
  } bundle_t;

  bundle_t    mem [2];
  bundle_t    in_bundle;
  bundle_t    head_bundle;
  logic       head;
  logic       tail;
  logic [1:0] count;
  logic       push;
  logic       pop;

  // Handshake: a transfer happens on a rising edge where valid & ready are both high
  // and flush is low; valid never waits on ready, and the producer holds its payload
  // until the transfer. A flush cycle discards any handshake on either side.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  assign in_bundle = '{pc: in_pc, instr: in_instr, op: in_op, sextimm: in_sextimm,
                       rs1_data: in_rs1_data, rs2_data: in_rs2_data, rd: in_rd,
                       wen: in_wen};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      // Payload is only ever written at the tail, so the head entry stays stable under stall.
      if (push) begin
        mem[tail] <= in_bundle;
        tail      <= ~tail;
      end
      if (pop) head <= ~head;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

  assign head_bundle  = mem[head];
  assign out_pc       = head_bundle.pc;
  assign out_instr    = head_bundle.instr;
  assign out_op       = head_bundle.op;
  assign out_sextimm  = head_bundle.sextimm;
  assign out_rs1_data = head_bundle.rs1_data;
  assign out_rs2_data = head_bundle.rs2_data;
  assign out_rd       = head_bundle.rd;
  assign out_wen      = head_bundle.wen;
  assign occupancy    = count;

endmodule

// File: tb/tb_decode_exec_skid.sv
// Directed and randomized checks of decode_exec_skid: reset, latency, stall stability,
// push/pop at count 1, flush, and a long scoreboard run.
module tb_decode_exec_skid;
  localparam int XLEN = 64;
  localparam int OP_W = 6;
  localparam int W    = 3 * XLEN + XLEN + 32 + OP_W + 5 + 1;
  localparam int N_RAND = 10000;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc, in_sextimm, in_rs1_data, in_rs2_data;
  logic [31:0]     in_instr;
  logic [OP_W-1:0] in_op;
  logic [4:0]      in_rd;
  logic            in_wen;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc, out_sextimm, out_rs1_data, out_rs2_data;
  logic [31:0]     out_instr;
  logic [OP_W-1:0] out_op;
  logic [4:0]      out_rd;
  logic            out_wen;
  logic [1:0]      occupancy;

  logic [W-1:0] out_b;
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  decode_exec_skid #(.XLEN(XLEN), .OP_W(OP_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_op(in_op), .in_sextimm(in_sextimm),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_rd(in_rd), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_op(out_op), .out_sextimm(out_sextimm),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rd(out_rd),
    .out_wen(out_wen), .occupancy(occupancy)
  );

  // clock / reset
  always #5 clk = ~clk;

  assign out_b = {out_pc, out_instr, out_op, out_sextimm, out_rs1_data, out_rs2_data,
                  out_rd, out_wen};

  function automatic logic [W-1:0] mk(input logic [XLEN-1:0] pc, input logic [31:0] instr,
                                      input logic [OP_W-1:0] op, input logic [XLEN-1:0] imm,
                                      input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2,
                                      input logic [4:0] rd, input logic wen);
    return {pc, instr, op, imm, r1, r2, rd, wen};
  endfunction

  function automatic logic [W-1:0] rand_bundle();
    logic [W-1:0] b;
    b = '0;
    for (int i = 0; i < (W + 31) / 32; i++) b = (b << 32) | W'($urandom);
    return b;
  endfunction

  // driver tasks
  task automatic drive(input logic [W-1:0] b);
    {in_pc, in_instr, in_op, in_sextimm, in_rs1_data, in_rs2_data, in_rd, in_wen} = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] a_b, b_b, c0_b, c1_b, d_b, e_b, f_b, g_b;
  int sent, recv, cycles;

  initial begin
    a_b  = mk(64'h0000_0000_8000_0000, 32'hFFC0_0093, 6'd5, 64'hFFFF_FFFF_FFFF_FFFC,
              64'h1111, 64'h2222, 5'd1, 1'b1);
    b_b  = mk(64'h8000_0004, 32'h0010_8113, 6'd7, 64'h1, 64'h3333, 64'h4444, 5'd2, 1'b0);
    c0_b = mk(64'h8000_0100, 32'hDEAD_BEEF, 6'd63, 64'h7FF, 64'hA5A5, 64'h5A5A, 5'd31, 1'b1);
    c1_b = mk(64'h8000_0104, 32'h1234_5678, 6'd42, 64'hFFFF_FFFF_FFFF_F800, 64'hC,
              64'hD, 5'd17, 1'b0);
    d_b  = mk(64'h9000_0000, 32'h1, 6'd1, 64'h10, 64'h20, 64'h30, 5'd3, 1'b1);
    e_b  = mk(64'h9000_0004, 32'h2, 6'd2, 64'h40, 64'h50, 64'h60, 5'd4, 1'b1);
    f_b  = mk(64'h9000_0008, 32'h3, 6'd3, 64'h70, 64'h80, 64'h90, 5'd5, 1'b0);
    g_b  = mk(64'hA000_0000, 32'h4, 6'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h2, 5'd6, 1'b1);

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive('0);
    #3;
    chk("reset_out_valid", W'(out_valid), W'(0));
    chk("reset_in_ready", W'(in_ready), W'(1));
    chk("reset_occ", W'(occupancy), W'(0));
    chk("reset_payload", out_b, '0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Single bundle with consumer ready: visible next cycle, then gone
    drive(a_b); in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_valid", W'(out_valid), W'(1));
    chk("lat_payload", out_b, a_b);
    chk("lat_occ", W'(occupancy), W'(1));
    step();
    chk("lat_drain_valid", W'(out_valid), W'(0));
    chk("lat_drain_occ", W'(occupancy), W'(0));

    // Stall: A and B buffered, A stable, then drained in order
    out_ready = 1'b0;
    drive(a_b); in_valid = 1'b1;
    step();
    drive(b_b);
    step();
    in_valid = 1'b0; drive('0);
    chk("stall_in_ready", W'(in_ready), W'(0));
    chk("stall_occ", W'(occupancy), W'(2));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_hold_payload", out_b, a_b);
      chk("stall_hold_valid", W'(out_valid), W'(1));
    end
    out_ready = 1'b1;
    step();
    chk("release_b", out_b, b_b);
    chk("release_b_occ", W'(occupancy), W'(1));
    chk("release_in_ready", W'(in_ready), W'(1));
    step();
    chk("release_empty", W'(out_valid), W'(0));

    // Push and pop together at count 1
    out_ready = 1'b0;
    drive(c0_b); in_valid = 1'b1;
    step();
    chk("pp_head", out_b, c0_b);
    drive(c1_b); out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("pp_new_head", out_b, c1_b);
    chk("pp_occ", W'(occupancy), W'(1));
    step();
    chk("pp_drain", W'(occupancy), W'(0));

    // Flush with a full buffer and a bundle on the input
    out_ready = 1'b0;
    drive(d_b); in_valid = 1'b1;
    step();
    drive(e_b);
    step();
    chk("pre_flush_occ", W'(occupancy), W'(2));
    drive(f_b); in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", W'(out_valid), W'(0));
    chk("flush_occ", W'(occupancy), W'(0));
    chk("flush_in_ready", W'(in_ready), W'(1));
    step();
    chk("flush_dropped", W'(occupancy), W'(0));
    drive(g_b); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_flush_payload", out_b, g_b);
    step();
    chk("post_flush_drain", W'(out_valid), W'(0));

    // Asynchronous reset with two entries held
    out_ready = 1'b0;
    drive(d_b); in_valid = 1'b1;
    step();
    drive(e_b);
    step();
    in_valid = 1'b0;
    chk("pre_rst_occ", W'(occupancy), W'(2));
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", W'(out_valid), W'(0));
    chk("async_rst_occ", W'(occupancy), W'(0));
    chk("async_rst_pc", W'(out_pc), W'(0));
    #1 reset = 1'b1;
    step();
    chk("post_rst_in_ready", W'(in_ready), W'(1));
    chk("post_rst_occ", W'(occupancy), W'(0));

    // Random traffic against the scoreboard
    sent = 0; recv = 0; cycles = 0;
    exp_q.delete();
    while ((sent < N_RAND || recv < N_RAND) && cycles < 80000) begin
      in_valid  = (sent < N_RAND) && ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      drive(rand_bundle());
      #0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("rand_unexpected_pop", out_b, '0 - 1'b1);
        else chk("rand_payload", out_b, exp_q.pop_front());
        recv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_pc, in_instr, in_op, in_sextimm, in_rs1_data, in_rs2_data,
                         in_rd, in_wen});
        sent++;
      end
      step();
      cycles++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rand_recv_count", W'(recv), W'(N_RAND));
    chk("rand_queue_empty", W'(exp_q.size()), W'(0));
    chk("rand_final_occ", W'(occupancy), W'(0));

    // report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
